// File: rtl/ppcpu_spi_pkg.sv
// Shared types and defaults for the SPI load/debug controller.
package ppcpu_spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WE,
      DATA,
      BUS,
      DONE,
      STAT,
      RDOUT
   } state_t;

   localparam int ADDR_W_DEF      = 24;
   localparam int DATA_W_DEF      = 16;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int TIMEOUT_DEF     = 255;
   localparam int TMO_W           = 8;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises the host SPI clock and data into the system clock domain and
// turns the synced clock into single-cycle rise/fall pulses.
module spi_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_clk,
   input  logic spi_mosi,
   output logic rise,
   output logic fall,
   output logic mosi
);

   logic [SYNC_STAGES-1:0] clk_sr;
   logic [SYNC_STAGES-1:0] mosi_sr;
   logic                   clk_d;

   // Both lines reset to their idle-high level so no false edge appears after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sr  <= '1;
         mosi_sr <= '1;
         clk_d   <= 1'b1;
      end else begin
         clk_sr  <= {clk_sr[SYNC_STAGES-2:0], spi_clk};
         mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
         clk_d   <= clk_sr[SYNC_STAGES-1];
      end
   end

   assign rise = clk_sr[SYNC_STAGES-1] & ~clk_d;
   assign fall = ~clk_sr[SYNC_STAGES-1] & clk_d;
   assign mosi = mosi_sr[SYNC_STAGES-1];

endmodule

// File: rtl/spi_load_ctrl.sv
// SPI-slave load/debug controller: deserialises host frames and issues single
// bus reads/writes, then reports busy/status/read data back on MISO.
module spi_load_ctrl
   import ppcpu_spi_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_spi_clk,
   input  logic              i_spi_mosi,
   output logic              o_spi_miso,
   output logic              o_req,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ack,
   input  logic              i_err,
   output logic              o_active
);

   localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = $clog2(MAX_W + 1);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [ADDR_W-1:0] addr_sh, addr_sh_nx, addr_nx;
   logic [DATA_W-1:0] data_sh, data_sh_nx, data_nx;
   logic [DATA_W-1:0] rd_sh, rd_sh_nx;
   logic [TMO_W-1:0]  tmo, tmo_nx;
   logic              we_bit, we_bit_nx;
   logic              frame_err, frame_err_nx;
   logic              sticky_err, sticky_err_nx;
   logic              req_nx, we_nx, miso_nx, active_nx;
   logic              rise, fall, mosi;

   spi_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .spi_clk  (i_spi_clk),
      .spi_mosi (i_spi_mosi),
      .rise     (rise),
      .fall     (fall),
      .mosi     (mosi)
   );

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         addr_sh    <= '0;
         data_sh    <= '0;
         rd_sh      <= '0;
         tmo        <= '0;
         we_bit     <= 1'b0;
         frame_err  <= 1'b0;
         sticky_err <= 1'b0;
         o_req      <= 1'b0;
         o_we       <= 1'b0;
         o_addr     <= '0;
         o_data     <= '0;
         o_spi_miso <= 1'b1;
         o_active   <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         addr_sh    <= addr_sh_nx;
         data_sh    <= data_sh_nx;
         rd_sh      <= rd_sh_nx;
         tmo        <= tmo_nx;
         we_bit     <= we_bit_nx;
         frame_err  <= frame_err_nx;
         sticky_err <= sticky_err_nx;
         o_req      <= req_nx;
         o_we       <= we_nx;
         o_addr     <= addr_nx;
         o_data     <= data_nx;
         o_spi_miso <= miso_nx;
         o_active   <= active_nx;
      end
   end

   // Next-state, frame shifting, bus handshake and MISO sequencing.
   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      addr_sh_nx    = addr_sh;
      data_sh_nx    = data_sh;
      rd_sh_nx      = rd_sh;
      tmo_nx        = tmo;
      we_bit_nx     = we_bit;
      frame_err_nx  = frame_err;
      sticky_err_nx = sticky_err;
      req_nx        = o_req;
      we_nx         = o_we;
      addr_nx       = o_addr;
      data_nx       = o_data;
      miso_nx       = o_spi_miso;
      active_nx     = o_active;

      case (state)
         IDLE: begin
            if (rise && !mosi) begin
               state_nx     = ADDR;
               cnt_nx       = '0;
               active_nx    = 1'b1;
               frame_err_nx = 1'b0;
            end
         end
         ADDR: begin
            if (rise) begin
               addr_sh_nx = {mosi, addr_sh[ADDR_W-1:1]};
               cnt_nx     = cnt + 1'b1;
               if (cnt == CNT_W'(ADDR_W - 1)) state_nx = WE;
            end
         end
         WE: begin
            if (rise) begin
               we_bit_nx = mosi;
               cnt_nx    = '0;
               state_nx  = mosi ? DATA : BUS;
            end
         end
         DATA: begin
            if (rise) begin
               data_sh_nx = {mosi, data_sh[DATA_W-1:1]};
               cnt_nx     = cnt + 1'b1;
               if (cnt == CNT_W'(DATA_W - 1)) state_nx = BUS;
            end
         end
         BUS: begin
            // First cycle in BUS presents the frame on the bus; request stays
            // up until ack, error (which wins) or the timeout expires.
            if (!o_req) begin
               req_nx  = 1'b1;
               tmo_nx  = '0;
               we_nx   = we_bit;
               addr_nx = addr_sh;
               if (we_bit) data_nx = data_sh;
            end else if (i_err || (!i_ack && tmo == TMO_W'(TIMEOUT - 1))) begin
               req_nx        = 1'b0;
               frame_err_nx  = 1'b1;
               sticky_err_nx = 1'b1;
               cnt_nx        = '0;
               state_nx      = DONE;
            end else if (i_ack) begin
               req_nx   = 1'b0;
               cnt_nx   = '0;
               state_nx = DONE;
               if (!o_we) rd_sh_nx = i_data;
            end else begin
               tmo_nx = tmo + 1'b1;
            end
         end
         DONE: begin
            if (fall) begin
               if (cnt == '0) begin
                  miso_nx = 1'b0;
                  cnt_nx  = CNT_W'(1);
               end else begin
                  miso_nx  = frame_err;
                  state_nx = STAT;
               end
            end
         end
         STAT: begin
            if (fall) begin
               if (we_bit) begin
                  miso_nx   = 1'b1;
                  active_nx = 1'b0;
                  state_nx  = IDLE;
               end else begin
                  miso_nx  = rd_sh[0];
                  rd_sh_nx = rd_sh >> 1;
                  cnt_nx   = CNT_W'(1);
                  state_nx = RDOUT;
               end
            end
         end
         RDOUT: begin
            if (fall) begin
               if (cnt == CNT_W'(DATA_W)) begin
                  miso_nx   = 1'b1;
                  active_nx = 1'b0;
                  state_nx  = IDLE;
               end else begin
                  miso_nx  = rd_sh[0];
                  rd_sh_nx = rd_sh >> 1;
                  cnt_nx   = cnt + 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: doc/spi_load_ctrl.md
Name: spi_load_ctrl

Overview:
- SPI-slave load/debug controller for embed mode: deserialises host frames on spi_clk/spi_mosi and issues single 16-bit reads/writes on the internal bus master port.
- Used to preload program memory while the core is held by core_disable.
- Reports busy/status/read data on spi_miso.
- Sits between the embed-mode GPIO pins and the bus arbiter's external master slot.

Parameters:
- ADDR_W, 24, bus address width (frame address field width)
- DATA_W, 16, bus data width (frame data field width)
- SYNC_STAGES, 2, synchroniser depth for spi_clk/spi_mosi
- TIMEOUT, 255, bus cycles without ack/err before abort (8-bit counter)

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_spi_clk  in  1  host SPI clock (asynchronous, idles high)
- i_spi_mosi  in  1  host data (asynchronous, idles high)
- o_spi_miso  out  1  busy/status/read data
- o_req  out  1  bus request, held until i_ack or i_err
- o_we  out  1  bus write enable
- o_addr  out  ADDR_W  bus address
- o_data  out  DATA_W  bus write data
- i_data  in  DATA_W  bus read data, valid with i_ack
- i_ack  in  1  bus transfer done
- i_err  in  1  bus transfer error
- o_active  out  1  high from start bit until frame end (for arbiter priority)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (i_rst_n).
- Reset values: o_spi_miso=1, o_req=0, o_we=0, o_addr=0, o_data=0, o_active=0, state=IDLE, sticky_err=0.
- Input handling: spi_clk/mosi pass through SYNC_STAGES flops. A "rise" is a synced 0->1 transition; mosi is sampled on rise. A "fall" is a synced 1->0 transition; o_spi_miso updates only on fall.
- Frame format, all fields LSB-first: start bit 0; ADDR_W address bits; we bit; DATA_W data bits only if we=1.
- IDLE: rise with mosi=0 -> ADDR, bit counter cleared, o_active=1. Rise with mosi=1 stays IDLE, so extra init clocks are harmless.
- ADDR: shift ADDR_W bits, then -> WE.
- WE: sample bit. 1 -> DATA. 0 -> BUS.
- DATA: shift DATA_W bits, then -> BUS.
- BUS: entered on the rise after the last frame bit. Next i_clk: o_req=1, o_we/o_addr/o_data stable. Hold until i_ack or i_err (same cycle as o_req allowed). If both are high, i_err wins. On i_ack for a read, latch i_data. Timeout counter increments each cycle o_req is high; at TIMEOUT, deassert o_req and flag an error. Exit to DONE with o_req=0 the next cycle. o_spi_miso stays 1 throughout BUS; spi edges are ignored.
- DONE: on next fall, o_spi_miso=0 (host sees "not busy"). On the following fall, o_spi_miso=err of this frame. Then -> STAT.
- STAT (after status bit is presented):
  - write -> IDLE on next fall, o_spi_miso=1, o_active=0.
  - read -> RDOUT.
- RDOUT: on each fall drive latched read data LSB-first, DATA_W bits. On the fall after the last bit, o_spi_miso=1 and -> IDLE.
- sticky_err: set on any bus error or timeout; cleared only by reset.
- Reset mid-frame or mid-bus cycle: immediate return to reset values. Any partial frame is discarded, and o_req drops asynchronously.
- Synchronised spi_clk held high or low indefinitely: no timeout on the SPI side; the state is retained.
- Address wraps naturally; there is no auto-increment.

Decomposition:
- Shared package ppcpu_spi_pkg: state enum (IDLE, ADDR, WE, DATA, BUS, DONE, STAT, RDOUT), frame field widths, TIMEOUT default.
- Sub-module spi_edge_sync: synchroniser plus rise/fall pulse generation for spi_clk, and synced mosi.
- FSM, shift registers, bus master and timeout counter live in spi_load_ctrl.

Test Plan:
- Write 0x800021 <= 0x3888, slave acks after 3 cycles -> exactly one o_req with o_we=1, o_addr=0x800021, o_data=0x3888. o_spi_miso is 1 until after ack, then 0, then status bit 0.
- Four back-to-back writes 0x800000..0x800003 of 0x000e, 0x0010, 0x000e, 0x0001 -> four bus writes in order with matching values. Two leading idle clocks (mosi=1) produce no transfer.
- Read 0x000042 with i_data=0xA5C3 acked -> o_we=0, status 0, then MISO bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB-first 0xA5C3), then MISO=1 idle.
- Slave asserts i_err on write -> o_req drops next cycle, status bit 1, sticky_err=1. Simultaneous i_ack and i_err gives the same result.
- No ack for TIMEOUT=255 cycles -> o_req deasserts at cycle 255, status bit 1, FSM returns to IDLE.
- Assert i_rst_n=0 during DATA field, then resend a full write frame -> no bus transfer for the aborted frame, and the new frame completes normally.
